// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM state type and timing defaults for the pong button path
package pong_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} t_sw_state;
  localparam int c_CLK_HZ = 25000000;
  localparam int c_HOLD_DELAY_DEFAULT = c_CLK_HZ / 2;
  localparam int c_REPEAT_PERIOD_DEFAULT = c_CLK_HZ / 10;
endpackage

// File: rtl/switch_edge_detect.sv
// switch_edge_detect: previous-level register with rising/falling strobes
module switch_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Level,
  output logic o_Rise,
  output logic o_Fall
);
  logic r_Level;
  // previous level; cleared by reset so a level held through reset reads as a rise
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) r_Level <= 1'b0;
    else r_Level <= i_Level;
  assign o_Rise = i_Level & ~r_Level;
  assign o_Fall = ~i_Level & r_Level;
endmodule

// File: rtl/switch_event_gen.sv
// switch_event_gen: press/release/long/auto-repeat events from a debounced switch (repeat logic under SWITCH_EVENT_REPEAT_EN)
module switch_event_gen
  import pong_pkg::*;
#(
  parameter int c_HOLD_DELAY = c_HOLD_DELAY_DEFAULT,
  parameter int c_REPEAT_PERIOD = c_REPEAT_PERIOD_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Step
);
  localparam int c_CNT_W = $clog2(c_HOLD_DELAY > c_REPEAT_PERIOD ? c_HOLD_DELAY : c_REPEAT_PERIOD) + 1;
  // r_Count is 1 on the edge after the press, so it equals the edges elapsed since E
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(c_HOLD_DELAY);
`ifdef SWITCH_EVENT_REPEAT_EN
  localparam logic [c_CNT_W-1:0] c_REP_LAST = c_CNT_W'(c_REPEAT_PERIOD - 1);
`endif
  t_sw_state r_State, w_State;
  logic [c_CNT_W-1:0] r_Count, w_Count;
  logic w_Press, w_Release, w_Long, w_Repeat;
  logic w_Rise, w_Fall;
  switch_edge_detect u_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Level (i_Switch),
    .o_Rise  (w_Rise),
    .o_Fall  (w_Fall)
  );
  // state, counter and registered event outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      r_State   <= IDLE;
      r_Count   <= '0;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
      o_Long    <= 1'b0;
      o_Repeat  <= 1'b0;
      o_Step    <= 1'b0;
    end else begin
      r_State   <= w_State;
      r_Count   <= w_Count;
      o_Press   <= w_Press;
      o_Release <= w_Release;
      o_Long    <= w_Long;
      o_Repeat  <= w_Repeat;
      o_Step    <= w_Press | w_Repeat;
    end
  // next state and next-cycle event values; a release always beats a due repeat
  always_comb begin
    w_State   = r_State;
    w_Count   = r_Count;
    w_Press   = 1'b0;
    w_Release = 1'b0;
    w_Long    = o_Long;
    w_Repeat  = 1'b0;
    case (r_State)
      IDLE:
        if (w_Rise) begin
          w_State = HOLD;
          w_Press = 1'b1;
          w_Count = c_CNT_W'(1);
        end
      HOLD:
        if (w_Fall) begin
          w_State   = IDLE;
          w_Release = 1'b1;
          w_Long    = 1'b0;
          w_Count   = '0;
        end else if (r_Count == c_HOLD_LAST) begin
          w_Long = 1'b1;
`ifdef SWITCH_EVENT_REPEAT_EN
          w_State  = REPEAT;
          w_Repeat = 1'b1;
          w_Count  = '0;
`endif
        end else w_Count = r_Count + 1'b1;
`ifdef SWITCH_EVENT_REPEAT_EN
      REPEAT:
        if (w_Fall) begin
          w_State   = IDLE;
          w_Release = 1'b1;
          w_Long    = 1'b0;
          w_Count   = '0;
        end else if (r_Count == c_REP_LAST) begin
          w_Repeat = 1'b1;
          w_Count  = '0;
        end else w_Count = r_Count + 1'b1;
`endif
      default: begin
        w_State = IDLE;
        w_Count = '0;
        w_Long  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_switch_event_gen.sv
// tb_switch_event_gen: scoreboard bench with a press-duration reference model
module tb_switch_event_gen;
  localparam int HOLD = 8;
  localparam int PER = 3;
`ifdef SWITCH_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b1;
  logic o_press, o_release, o_long, o_repeat, o_step;
  int n_tests = 0;
  int n_fail = 0;
  logic [4:0] q[$];
  bit m_pressed = 0;
  int m_n = 0;
  bit m_long = 0;
  switch_event_gen #(.c_HOLD_DELAY(HOLD), .c_REPEAT_PERIOD(PER)) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Switch  (sw),
    .o_Press   (o_press),
    .o_Release (o_release),
    .o_Long    (o_long),
    .o_Repeat  (o_repeat),
    .o_Step    (o_step)
  );
  initial forever #5 clk = ~clk;
  function automatic logic [4:0] outs();
    return {o_press, o_release, o_long, o_repeat, o_step};
  endfunction
  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {press,release,long,repeat,step}=%b expected %b", name, $time, act, exp);
    end
  endtask
  // expected outputs from edges elapsed since the press edge E
  task automatic model(input logic s);
    logic pr, rl, rp;
    pr = 0; rl = 0; rp = 0;
    if (!m_pressed && s) begin
      pr = 1; m_pressed = 1; m_n = 0;
    end else if (m_pressed && !s) begin
      rl = 1; m_pressed = 0; m_long = 0;
    end else if (m_pressed) begin
      m_n++;
      if (m_n >= HOLD) m_long = 1;
      if (REP_EN && m_n >= HOLD && (m_n - HOLD) % PER == 0) rp = 1;
    end
    q.push_back({pr, rl, m_long, rp, pr | rp});
  endtask
  task automatic cyc(input logic s);
    @(negedge clk);
    sw = s;
    @(posedge clk);
    if (rst_n) model(s);
  endtask
  task automatic run(input logic s, input int n);
    for (int i = 0; i < n; i++) cyc(s);
  endtask
  task automatic assert_reset();
    #3 rst_n = 1'b0;
    q.delete();
    m_pressed = 0; m_n = 0; m_long = 0;
    #1 check("async_reset", outs(), 5'b0);
  endtask
  // monitor: pops one expected vector per cycle, holds the last one otherwise
  initial begin
    logic [4:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = '0;
        check("in_reset", outs(), 5'b0);
      end else begin
        if (q.size() > 0) last = q.pop_front();
        check("scoreboard", outs(), last);
      end
    end
  end
  initial begin
    run(1, 3);
    #2 rst_n = 1'b1;
    run(1, 13);
    run(0, 3);
    run(1, 5);
    run(0, 3);
    run(1, 20);
    run(0, 3);
    run(1, 11);
    run(0, 3);
    run(1, 4);
    run(0, 1);
    run(1, 10);
    run(0, 2);
    run(1, 10);
    assert_reset();
    run(1, 2);
    #2 rst_n = 1'b1;
    run(1, 13);
    run(0, 3);
    for (int k = 0; k < 60; k++) run(logic'($urandom_range(0, 1)), $urandom_range(1, 14));
    run(0, 4);
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
